mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
Parametrised synthesizable memory master. It replaces the fixed 5-bit-address, 8-bit-data single-beat write/read tasks with an RTL engine that accepts burst requests over a valid/ready handshake. It drives the memory's read, write, addr and data_in signals and returns read data as a timed stream. It sits between test or DUT-side agents and the synchronous memory design, supporting wrap-around bursts and write-data stalls.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W
DATA_W, 8, memory data width
MAX_BURST, 8, maximum beats per request (power of 2, >=2)
LEN_W, $clog2(MAX_BURST), derived width of req_len (localparam)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  controller can accept request
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_W  burst start address
req_len  input  LEN_W  beats minus one
wdata_valid  input  1  write beat valid
wdata_ready  output  1  write beat accepted
wdata  input  DATA_W  write beat data
rdata_valid  output  1  read beat valid (no backpressure)
rdata  output  DATA_W  read beat data
rdata_last  output  1  final beat of read burst
busy  output  1  state != IDLE or read pipe non-empty
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_data_in  output  DATA_W  data to memory
mem_data_out  input  DATA_W  data from memory, valid the cycle after mem_read is sampled

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0 except req_ready=0 while in reset. The read pipe is flushed and beat counters are cleared. Reset release gives req_ready=1 on the first cycle.
- States: IDLE, WR, RD, DRAIN. Cycle k means the interval after posedge Ek.
- IDLE: req_ready=1. Handshake at E0 when req_valid && req_ready. It latches addr, len and write, sets beats = len+1, and goes to WR or RD.
- WR: wdata_ready=1 (combinational from state).
  - Each edge with wdata_valid registers mem_write=1, mem_addr=cur_addr, mem_data_in=wdata, then increments cur_addr.
  - Edge without wdata_valid: mem_write<=0; cur_addr and count unchanged.
  - After the last beat is accepted, go to IDLE. That beat's mem_write is visible in the first IDLE cycle. A new request may be accepted in that same cycle.
- RD: at E0 register mem_read=1 with mem_addr=req_addr. mem_read stays high in cycles 0..len, with the address incrementing each cycle.
  - At the edge ending cycle len, go to DRAIN with mem_read<=0.
  - Each issued read pushes a tag bit into a 2-stage valid pipe; the last beat also pushes a last bit.
- Read data timing: mem_data_out is captured 2 edges after the read issue. rdata_valid is high in cycles 2..len+2, rdata_last is high in cycle len+2, and rdata/rdata_last are 0 when not valid.
- DRAIN: remains until the pipe is empty, then goes to IDLE. req_ready returns in cycle len+3.
- Address arithmetic: modulo 2**ADDR_W, so it wraps (31 -> 0 for ADDR_W=5).
- Other rules:
  - mem_read and mem_write are never high in the same cycle.
  - req_valid while req_ready=0 is ignored; the requester holds it.
  - wdata_valid outside WR is ignored (wdata_ready=0).
- Reset mid-burst: immediate abort with outputs 0. In-flight read data is discarded; no partial rdata_last.

Decomposition:
- Package mem_ctrl_pkg: state_t enum (IDLE, WR, RD, DRAIN) and default ADDR_W/DATA_W/MAX_BURST constants.
- Sub-module mem_rd_pipe: 2-stage valid/last shift register plus data capture register, parametrised by DATA_W.

Test Plan:
- Reset mid-idle and mid-read: all outputs 0 asynchronously. After release, req_ready=1 in the first cycle and busy=0.
- Single write, addr 5, data A5, len 0: one mem_write cycle with addr 5 and data A5. req_ready is high again the same cycle.
- Burst write, addr 30, len 3, data 11,22,33,44: mem_write beats at addr 30,31,0,1 (wrap). Memory model holds those values.
- Burst read, addr 30, len 3, after the previous write: mem_read high 4 cycles. rdata 11,22,33,44 in cycles 2..5, rdata_last only in cycle 5, req_ready back in cycle 6.
- Write stall, len 2, wdata_valid pattern 1,0,0,1,1: mem_write pattern 1,0,0,1,1 and addresses advance only on accepted beats.
- Reset during read burst, addr 0, len 7, rst_n low in cycle 3: no further rdata_valid. A new read of addr 0 len 0 then returns correct data with latency 2.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the burst memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/mem_rd_pipe.sv
// Two-stage read return pipe: stage 1 tracks a read the memory has just
// sampled, stage 2 captures the memory data and presents it as a beat.
module mem_rd_pipe
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic              push_last,
    input  logic [DATA_W-1:0] data_in,
    output logic              stage_busy,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] out_data
);

    logic s1_valid;
    logic s1_last;

    // Shift the valid/last tags and capture data only when a beat is due,
    // so rdata and rdata_last stay at zero between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            s1_valid  <= push_valid;
            s1_last   <= push_valid & push_last;
            out_valid <= s1_valid;
            out_last  <= s1_valid & s1_last;
            out_data  <= s1_valid ? data_in : '0;
        end
    end

    // Stage 1 still holds a beat that has not reached the output yet.
    assign stage_busy = s1_valid;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst memory master: accepts write/read burst requests, drives the
// synchronous memory strobes and streams read data back with fixed latency.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int LEN_W     = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;   // beats still to issue after the current one
    logic              read_last;   // travels alongside mem_read for the final beat
    logic              pipe_busy;

    // Burst sequencer: all memory strobes are registered here; address
    // arithmetic wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            read_last   <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            read_last <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_len;
                        if (req_write) begin
                            state    <= WR;
                            cur_addr <= req_addr;
                        end else begin
                            // First read issues on the handshake edge itself.
                            state     <= RD;
                            mem_read  <= 1'b1;
                            mem_addr  <= req_addr;
                            cur_addr  <= req_addr + 1'b1;
                            read_last <= (req_len == '0);
                        end
                    end
                end
                WR: begin
                    if (wdata_valid) begin
                        mem_write   <= 1'b1;
                        mem_addr    <= cur_addr;
                        mem_data_in <= wdata;
                        cur_addr    <= cur_addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                        if (remaining == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else begin
                        mem_read  <= 1'b1;
                        mem_addr  <= cur_addr;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        read_last <= (remaining == LEN_W'(1));
                    end
                end
                DRAIN: begin
                    // Stage 2 emits its final beat in the cycle we leave.
                    if (!pipe_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rd_pipe #(
        .DATA_W(DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(mem_read),
        .push_last (read_last),
        .data_in   (mem_data_out),
        .stage_busy(pipe_busy),
        .out_valid (rdata_valid),
        .out_last  (rdata_last),
        .out_data  (rdata)
    );

    // Ready is suppressed while reset is asserted even though state is IDLE.
    assign req_ready   = rst_n && (state == IDLE);
    assign wdata_ready = (state == WR);
    assign busy        = (state != IDLE) || pipe_busy || rdata_valid;

endmodule
